// File: rtl/rc4_crack_scheduler.sv
// Work scheduler for NUM_CORES RC4 key-search cores: chunked dispatch, round-robin refill, abort on first hit.
// Define SCHED_PERF_EN to add the cycle_count / chunks_done performance counters.
module rc4_crack_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int KEY_BITS   = 22,
  parameter int CHUNK_BITS = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          start,
  output logic [KEY_BITS-1:0]           dispatch_key,
  output logic [NUM_CORES-1:0]          dispatch_valid,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES-1:0]          core_found,
  input  logic [NUM_CORES*KEY_BITS-1:0] core_found_key,
  output logic                          core_abort,
  output logic                          busy,
  output logic                          found,
  output logic                          exhausted,
  output logic [KEY_BITS-1:0]           key_out,
  output logic [9:0]                    progress
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]                   cycle_count,
  output logic [KEY_BITS-CHUNK_BITS:0]  chunks_done
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CORES - 1);
  localparam logic [KEY_BITS:0] CHUNK_INC = {{KEY_BITS{1'b0}}, 1'b1} << CHUNK_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_RUN,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t                state_q;
  logic [KEY_BITS:0]     next_base_q;
  logic [IDX_W-1:0]      disp_idx_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [NUM_CORES-1:0]  pend_q;
  logic [NUM_CORES-1:0]  pfound_q;
  logic [NUM_CORES-1:0]  core_idle_q;
  logic [NUM_CORES-1:0]  dispatch_valid_q;
  logic [KEY_BITS-1:0]   dispatch_key_q;
  logic [KEY_BITS-1:0]   key_out_q;
  logic                  busy_q;
  logic                  found_q;
  logic                  exhausted_q;
  logic                  abort_q;

  logic                  space_done;
  logic                  accept;
  logic                  svc_hit;
  logic [IDX_W-1:0]      svc_idx;
  logic [IDX_W-1:0]      cand;
  logic [NUM_CORES-1:0]  set_v;
  logic [NUM_CORES-1:0]  svc_oh;
  logic [NUM_CORES-1:0]  pend_d;
  logic [NUM_CORES-1:0]  pfound_d;
  logic [KEY_BITS-1:0]   svc_key;
  logic [KEY_BITS+9:0]   prog_pad;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return IDX_W'(s);
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign space_done = next_base_q[KEY_BITS];
  assign accept     = (state_q == S_DISPATCH) || (state_q == S_RUN);
  // A done pulse only counts for a core that actually holds a chunk.
  assign set_v      = core_done & ~core_idle_q & {NUM_CORES{accept}};

  always_comb begin
    svc_hit = 1'b0;
    svc_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!svc_hit && pend_q[cand]) begin
        svc_hit = 1'b1;
        svc_idx = cand;
      end
    end
  end

  always_comb begin
    svc_oh  = '0;
    svc_key = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (svc_idx == IDX_W'(n)) svc_key = core_found_key[n*KEY_BITS +: KEY_BITS];
    end
    if (state_q == S_RUN && svc_hit) svc_oh[svc_idx] = 1'b1;
  end

  // A serviced core has its latch cleared even if it pulses again in that cycle.
  assign pend_d   = (pend_q | set_v) & ~svc_oh;
  assign pfound_d = ((pfound_q & ~set_v) | (core_found & set_v)) & ~svc_oh;

  // Left-align the key so narrow key spaces still light the top LEDs.
  assign prog_pad = {next_base_q[KEY_BITS-1:0], 10'b0};
  assign progress = prog_pad[KEY_BITS+9 -: 10];

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      next_base_q      <= '0;
      disp_idx_q       <= '0;
      rr_ptr_q         <= '0;
      pend_q           <= '0;
      pfound_q         <= '0;
      core_idle_q      <= '1;
      dispatch_valid_q <= '0;
      dispatch_key_q   <= '0;
      key_out_q        <= '0;
      busy_q           <= 1'b0;
      found_q          <= 1'b0;
      exhausted_q      <= 1'b0;
      abort_q          <= 1'b0;
    end else begin
      dispatch_valid_q <= '0;
      pend_q           <= pend_d;
      pfound_q         <= pfound_d;
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            state_q     <= S_DISPATCH;
            busy_q      <= 1'b1;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            abort_q     <= 1'b0;
            key_out_q   <= '0;
            pend_q      <= '0;
            pfound_q    <= '0;
            next_base_q <= '0;
            disp_idx_q  <= '0;
            rr_ptr_q    <= '0;
            core_idle_q <= '1;
          end
        end
        S_DISPATCH: begin
          if (!space_done) begin
            dispatch_valid_q        <= onehot(disp_idx_q);
            dispatch_key_q          <= next_base_q[KEY_BITS-1:0];
            next_base_q             <= next_base_q + CHUNK_INC;
            core_idle_q[disp_idx_q] <= 1'b0;
          end
          if (disp_idx_q == LAST_IDX) state_q <= S_RUN;
          else disp_idx_q <= disp_idx_q + 1'b1;
        end
        S_RUN: begin
          if (svc_hit) begin
            rr_ptr_q <= (svc_idx == LAST_IDX) ? '0 : svc_idx + 1'b1;
            if (pfound_q[svc_idx]) begin
              key_out_q   <= svc_key;
              state_q     <= S_FOUND;
              found_q     <= 1'b1;
              busy_q      <= 1'b0;
              abort_q     <= 1'b1;
              core_idle_q <= '1;
              pend_q      <= '0;
              pfound_q    <= '0;
            end else if (!space_done) begin
              dispatch_valid_q <= onehot(svc_idx);
              dispatch_key_q   <= next_base_q[KEY_BITS-1:0];
              next_base_q      <= next_base_q + CHUNK_INC;
            end else begin
              core_idle_q[svc_idx] <= 1'b1;
            end
          end else if (&core_idle_q && space_done) begin
            state_q     <= S_EXHAUSTED;
            exhausted_q <= 1'b1;
            busy_q      <= 1'b0;
            abort_q     <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dispatch_key   = dispatch_key_q;
  assign dispatch_valid = dispatch_valid_q;
  assign core_abort     = abort_q;
  assign busy           = busy_q;
  assign found          = found_q;
  assign exhausted      = exhausted_q;
  assign key_out        = key_out_q;

`ifdef SCHED_PERF_EN
  logic [31:0]                  cycle_count_q;
  logic [KEY_BITS-CHUNK_BITS:0] chunks_done_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cycle_count_q <= '0;
      chunks_done_q <= '0;
    end else if (start && !busy_q) begin
      cycle_count_q <= '0;
      chunks_done_q <= '0;
    end else begin
      if (busy_q && cycle_count_q != 32'hFFFF_FFFF) cycle_count_q <= cycle_count_q + 32'd1;
      if (state_q == S_RUN && svc_hit) chunks_done_q <= chunks_done_q + 1'b1;
    end
  end

  assign cycle_count = cycle_count_q;
  assign chunks_done = chunks_done_q;
`endif

endmodule

// File: tb/tb_rc4_crack_scheduler.sv
// Bench for rc4_crack_scheduler: behavioural crack cores with random latency, checked against chunk-level expectations.
module tb_rc4_crack_scheduler;
  localparam int NC     = 4;
  localparam int KB     = 8;
  localparam int CB     = 4;
  localparam int NCHUNK = 1 << (KB - CB);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KB-1:0]   dispatch_key;
  logic [NC-1:0]   dispatch_valid;
  logic [NC-1:0]   core_done = '0;
  logic [NC-1:0]   core_found = '0;
  logic [NC*KB-1:0] core_found_key = '0;
  logic            core_abort, busy, found, exhausted;
  logic [KB-1:0]   key_out;
  logic [9:0]      progress;
`ifdef SCHED_PERF_EN
  logic [31:0]     cycle_count;
  logic [KB-CB:0]  chunks_done;
`endif

  rc4_crack_scheduler #(.NUM_CORES(NC), .KEY_BITS(KB), .CHUNK_BITS(CB)) dut (
    .CLOCK_50      (clk),
    .reset         (rst_n),
    .start         (start),
    .dispatch_key  (dispatch_key),
    .dispatch_valid(dispatch_valid),
    .core_done     (core_done),
    .core_found    (core_found),
    .core_found_key(core_found_key),
    .core_abort    (core_abort),
    .busy          (busy),
    .found         (found),
    .exhausted     (exhausted),
    .key_out       (key_out),
    .progress      (progress)
`ifdef SCHED_PERF_EN
    ,
    .cycle_count   (cycle_count),
    .chunks_done   (chunks_done)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural core farm and dispatch log
  int            act[NC];
  int            cnt[NC];
  int            nth[NC];
  logic [KB-1:0] ckey[NC];
  int            seen_cnt[NCHUNK];
  int            dlog_core[$];
  int            dlog_key[$];
  int            dlog_cyc[$];
  int            cyc = 0;
  bit            auto_en;
  int            fcore, fnth, tchunk;
  logic [KB-1:0] fkey;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic env_reset();
    dlog_core.delete();
    dlog_key.delete();
    dlog_cyc.delete();
    for (int i = 0; i < NCHUNK; i++) seen_cnt[i] = 0;
    for (int n = 0; n < NC; n++) begin
      act[n] = 0;
      cnt[n] = 0;
      nth[n] = 0;
      ckey[n] = '0;
    end
    core_done  = '0;
    core_found = '0;
  endtask

  // One clock of the core farm: observe at the falling edge, then drive the next inputs.
  task automatic step(input bit st, input logic [NC-1:0] md, input logic [NC-1:0] mf);
    bit hit;
    @(negedge clk);
    cyc++;
    start      = st;
    core_done  = '0;
    core_found = '0;
    if (core_abort) for (int n = 0; n < NC; n++) act[n] = 0;
    if (dispatch_valid != '0) begin
      chk("dv_onehot", 64'($onehot(dispatch_valid)), 64'd1);
      chk("dk_aligned", 64'(dispatch_key[CB-1:0]), 64'd0);
    end
    for (int n = 0; n < NC; n++) begin
      if (dispatch_valid[n]) begin
        dlog_core.push_back(n);
        dlog_key.push_back(int'(dispatch_key));
        dlog_cyc.push_back(cyc);
        seen_cnt[int'(dispatch_key) >> CB]++;
        act[n]  = 1;
        cnt[n]  = int'($urandom_range(1, 5));
        nth[n]++;
        ckey[n] = dispatch_key;
      end else if (auto_en && act[n] != 0) begin
        cnt[n]--;
        if (cnt[n] == 0) begin
          act[n] = 0;
          hit = (n == fcore && nth[n] == fnth) || (tchunk >= 0 && int'(ckey[n]) == tchunk);
          core_done[n]  = 1'b1;
          core_found[n] = hit;
          core_found_key[n*KB +: KB] = hit ? fkey : ckey[n];
        end
      end
    end
    core_done  = core_done | md;
    core_found = core_found | mf;
  endtask

  task automatic run_to_end(input int budget);
    int i;
    i = 0;
    while (!(found || exhausted) && i < budget) begin
      step(1'b0, '0, '0);
      i++;
    end
    chk("end_reached", 64'(found || exhausted), 64'd1);
  endtask

  task automatic wait_disp(input int n, input int budget);
    int i;
    i = 0;
    while (dlog_key.size() < n && i < budget) begin
      step(1'b0, '0, '0);
      i++;
    end
    chk("disp_wait", 64'(dlog_key.size() >= n), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc0, r, n0;
    auto_en = 1'b1;
    fcore   = -1;
    fnth    = 0;
    tchunk  = -1;
    fkey    = '0;
    env_reset();

    // Power-on reset
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_exhausted", 64'(exhausted), 64'd0);
    chk("rst_abort", 64'(core_abort), 64'd0);
    chk("rst_dvalid", 64'(dispatch_valid), 64'd0);
    chk("rst_dkey", 64'(dispatch_key), 64'd0);
    chk("rst_keyout", 64'(key_out), 64'd0);
    chk("rst_progress", 64'(progress), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full search with no hit: initial sweep, every chunk exactly once, then exhausted
    env_reset();
    step(1'b1, '0, '0);
    cyc0 = cyc;
    step(1'b0, '0, '0);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("abort_after_start", 64'(core_abort), 64'd0);
    run_to_end(400);
    chk("exh_flag", 64'(exhausted), 64'd1);
    chk("exh_found", 64'(found), 64'd0);
    chk("exh_abort", 64'(core_abort), 64'd1);
    chk("exh_busy", 64'(busy), 64'd0);
    chk("exh_count", 64'(dlog_key.size()), 64'(NCHUNK));
    for (int i = 0; i < NCHUNK; i++) chk("exh_once", 64'(seen_cnt[i]), 64'd1);
    chk("init_latency", 64'((dlog_cyc[0] - cyc0) <= 3), 64'd1);
    for (int i = 0; i < NC; i++) begin
      chk("init_core", 64'(dlog_core[i]), 64'(i));
      chk("init_key", 64'(dlog_key[i]), 64'(i << CB));
      chk("init_consec", 64'(dlog_cyc[i] - dlog_cyc[0]), 64'(i));
    end

    // Restart from exhausted; a start while busy must not restart the sweep
    env_reset();
    step(1'b1, '0, '0);
    step(1'b0, '0, '0);
    chk("restart_found", 64'(found), 64'd0);
    chk("restart_exh", 64'(exhausted), 64'd0);
    chk("restart_abort", 64'(core_abort), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_disp(2, 10);
    step(1'b1, '0, '0);
    run_to_end(400);
    chk("rs_exh_flag", 64'(exhausted), 64'd1);
    chk("rs_count", 64'(dlog_key.size()), 64'(NCHUNK));
    chk("rs_first_key", 64'(dlog_key[0]), 64'd0);
    chk("rs_first_core", 64'(dlog_core[0]), 64'd0);
    for (int i = 0; i < NCHUNK; i++) chk("rs_once", 64'(seen_cnt[i]), 64'd1);

    // Core 2 finds key 0x5A on its second chunk
    env_reset();
    fcore = 2;
    fnth  = 2;
    fkey  = 8'h5A;
    step(1'b1, '0, '0);
    step(1'b0, '0, '0);
    run_to_end(400);
    chk("c2_found", 64'(found), 64'd1);
    chk("c2_keyout", 64'(key_out), 64'h5A);
    chk("c2_abort", 64'(core_abort), 64'd1);
    chk("c2_exh", 64'(exhausted), 64'd0);
    chk("c2_busy", 64'(busy), 64'd0);
    chk("c2_core2_chunks", 64'(nth[2] >= 2), 64'd1);
    n0 = dlog_key.size();
    repeat (8) step(1'b0, '0, '0);
    chk("c2_no_disp_after", 64'(dlog_key.size()), 64'(n0));
    fcore = -1;

    // Random target chunk and random reported key
    repeat (3) begin
      env_reset();
      r      = int'($urandom_range(0, NCHUNK - 1));
      tchunk = r << CB;
      fkey   = 8'($urandom_range(0, 255));
      step(1'b1, '0, '0);
      step(1'b0, '0, '0);
      run_to_end(400);
      chk("rnd_found", 64'(found), 64'd1);
      chk("rnd_keyout", 64'(key_out), 64'(fkey));
      chk("rnd_target_once", 64'(seen_cnt[r]), 64'd1);
      for (int i = 0; i < NCHUNK; i++) chk("rnd_at_most_once", 64'(seen_cnt[i] <= 1), 64'd1);
    end
    tchunk = -1;

    // Cores 1 and 3 both find in one cycle with the round-robin pointer at 2
    auto_en = 1'b0;
    env_reset();
    step(1'b1, '0, '0);
    wait_disp(NC, 10);
    step(1'b0, 4'b0010, 4'b0000);
    wait_disp(NC + 1, 10);
    chk("redisp_core", 64'(dlog_core[NC]), 64'd1);
    chk("redisp_key", 64'(dlog_key[NC]), 64'h40);
    core_found_key[1*KB +: KB] = 8'h11;
    core_found_key[3*KB +: KB] = 8'h33;
    step(1'b0, 4'b1010, 4'b1010);
    run_to_end(20);
    chk("rr_found", 64'(found), 64'd1);
    chk("rr_keyout", 64'(key_out), 64'h33);
    auto_en = 1'b1;

    // Asynchronous reset in the middle of a search
    env_reset();
    step(1'b1, '0, '0);
    repeat (8) step(1'b0, '0, '0);
    chk("midrun_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_found", 64'(found), 64'd0);
    chk("mr_exh", 64'(exhausted), 64'd0);
    chk("mr_abort", 64'(core_abort), 64'd0);
    chk("mr_dvalid", 64'(dispatch_valid), 64'd0);
    chk("mr_dkey", 64'(dispatch_key), 64'd0);
    chk("mr_keyout", 64'(key_out), 64'd0);
    chk("mr_progress", 64'(progress), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    env_reset();
    step(1'b1, '0, '0);
    wait_disp(1, 6);
    chk("mr_first_core", 64'(dlog_core[0]), 64'd0);
    chk("mr_first_key", 64'(dlog_key[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
